freq_divider_prog: RTL
======================

# freq_divider_prog

Runtime-programmable integer clock divider. It produces a divided clock-enable waveform `out` for any divisor N ≥ 2, and N has a 50 % duty cycle for both even and odd values. Divisor changes are applied glitch-free at period boundaries, and a one-cycle `tick` strobe marks each period start. The block is the general successor to the fixed odd-only divider in the clock-generation area.

## Interface
Parameters:
- `WIDTH`, 8: width of divisor and internal counter.
- `DEFAULT_DIV`, 5: divisor applied out of reset; must satisfy 2 ≤ DEFAULT_DIV ≤ 2^WIDTH−1.

Ports:
- `clk`  in  1  single clock, all state on this clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable; low freezes all state.
- `div_in`  in  WIDTH  requested divisor.
- `div_load`  in  1  one-cycle strobe that captures `div_in`.
- `out`  out  1  divided waveform.
- `tick`  out  1  one-cycle pulse coincident with each `out` rising edge.
- `div_active`  out  WIDTH  divisor currently in effect.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- State:
  - `cnt` counts 0..N−1 on posedge `clk` while `en`=1.
  - `p` is a posedge register.
  - `n` is a negedge copy of `p`, present only with the macro.
  - `div_pend` and `pend_vld` hold a queued divisor.
- Count rule: at each enabled posedge, `cnt` ← 0 if `cnt`==N−1, else `cnt`+1. The transition to 0 is the wrap.
- `p` ← 1 when the next `cnt` < floor(N/2), else 0.
- Even N: `out` = `p`, so it is high N/2 cycles and low N/2 cycles.
- Odd N: see Configuration.
- `tick` is registered. It is 1 for exactly the cycle following each wrap posedge and 0 otherwise.
- Divisor load:
  - A `div_load` with `div_in` ≥ 2 sets `div_pend`←`div_in` and `pend_vld`←1.
  - A `div_load` with `div_in` < 2 pulses `load_err` the next cycle and changes no state.
- Apply:
  - At a wrap posedge with `pend_vld`=1, N←`div_pend`, `div_active` updates, and `pend_vld`←0.
  - The new period starting at that wrap uses the new N.
- Simultaneous events:
  - A load on the same cycle as a wrap is queued and applies at the following wrap.
  - A new load while `pend_vld`=1 overwrites `div_pend`; the last load wins.
  - Loads are accepted while `en`=0.
- `en`=0: `cnt`, `p`, `n`, `pend_vld` and `div_active` hold, and `out` holds its level. `tick` clears at the next posedge and does not reassert until the next wrap.

## Timing
- Reset values, applied asynchronously and immediately when `rst`=0:
  - `out`=0, `tick`=0, `load_err`=0.
  - `div_active`=DEFAULT_DIV, `pend_vld`=0.
  - `cnt`=DEFAULT_DIV−1, `p`=0, `n`=0.
- First enabled posedge after reset release wraps `cnt` to 0. `out` rises at that posedge, and `tick` is high for the following cycle.
- Period is N clk cycles. `out` rising edges are always aligned to posedge `clk`.
- Divisor change latency is 1 to N_old cycles: it takes effect at the next wrap after capture.
- `load_err` latency is 1 cycle.
- Reset asserted mid-period forces `out` low asynchronously with no runt pulse after release, and any pending load is discarded.

## Configuration
- Macro: `FREQ_DIV_ODD_EN`.
- Defined:
  - For odd N, `out` = `p` | `n`, giving high for N/2 cycles (floor(N/2)+0.5) and 50 % duty.
  - `n` is the only negedge flop in the block.
- Undefined:
  - No negedge logic is present, and `out` = `p` for all N.
  - For odd N, `out` is high floor(N/2) cycles and low ceil(N/2) cycles.
  - Even-N behaviour is identical in both builds.

## Test plan
- Reset and default: clk period 10 ns, DEFAULT_DIV=5, `en`=1, `rst` low 20 ns then high.
  - With `FREQ_DIV_ODD_EN`: `out` period 50 ns, high 25 ns.
  - Without: high 20 ns.
  - In both builds `tick` pulses every 50 ns, and `div_active`=5.
- Even divisor: load 4 then 6.
  - Periods are 40 ns and 60 ns, with high times of exactly 20 ns and 30 ns.
  - Each change takes effect only at a `tick` boundary, with no short pulse.
- Pending overwrite and same-cycle wrap:
  - Load 7 and then load 3 before the wrap: the next period is 3 cycles, and `div_active` goes 5→3.
  - A load issued on a wrap cycle applies one period later.
- Rejected load: `div_load` with `div_in`=1 or 0 → `load_err`=1 for one cycle, and `div_active` and the period are unchanged.
- Enable freeze: drop `en` for 7 cycles mid-high-phase.
  - `out` stays high and `cnt` holds.
  - After `en` returns, the remaining high time equals the remaining count, and total period = N + 7 cycles.
- Async reset mid-operation: assert `rst`=0 between clock edges while `out`=1.
  - `out` goes 0 within the same timestep.
  - All outputs take their reset values, and the first `out` rise comes at the first posedge after release.

Source files
------------

// File: rtl/freq_divider_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor reload at period boundaries.
// Define FREQ_DIV_ODD_EN to add a negedge flop that gives exact 50 % duty for odd divisors.
module freq_divider_prog #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             out,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(DEFAULT_DIV - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_active_q, div_active_d;
  logic [WIDTH-1:0] div_pend_q, div_pend_d;
  logic [WIDTH-1:0] div_next;
  logic             p_q, p_d;
  logic             pend_vld_q, pend_vld_d;
  logic             tick_q, tick_d;
  logic             load_err_q, load_err_d;
  logic             wrap;
  logic             load_ok;

  always_comb begin
    wrap         = (cnt_q == (div_active_q - WIDTH'(1)));
    load_ok      = div_load && (div_in >= WIDTH'(2));
    load_err_d   = div_load && (div_in < WIDTH'(2));
    cnt_d        = cnt_q;
    p_d          = p_q;
    div_active_d = div_active_q;
    div_pend_d   = div_pend_q;
    pend_vld_d   = pend_vld_q;
    tick_d       = 1'b0;
    div_next     = div_active_q;

    if (en) begin
      tick_d = wrap;
      if (wrap) begin
        cnt_d = '0;
        if (pend_vld_q) begin
          div_next     = div_pend_q;
          div_active_d = div_pend_q;
          pend_vld_d   = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
      // High phase is sized by the divisor of the period being entered.
      p_d = (cnt_d < (div_next >> 1));
    end

    // Evaluated after the apply so a load on a wrap cycle stays queued.
    if (load_ok) begin
      div_pend_d = div_in;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= CNT_RST;
      p_q          <= 1'b0;
      div_active_q <= DIV_RST;
      div_pend_q   <= DIV_RST;
      pend_vld_q   <= 1'b0;
      tick_q       <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      p_q          <= p_d;
      div_active_q <= div_active_d;
      div_pend_q   <= div_pend_d;
      pend_vld_q   <= pend_vld_d;
      tick_q       <= tick_d;
      load_err_q   <= load_err_d;
    end
  end

`ifdef FREQ_DIV_ODD_EN
  logic n_q;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) n_q <= 1'b0;
    else      n_q <= p_q;
  end

  // The half-cycle extension applies only to odd divisors.
  assign out = p_q | (n_q & div_active_q[0]);
`else
  assign out = p_q;
`endif

  assign tick       = tick_q;
  assign div_active = div_active_q;
  assign load_err   = load_err_q;

endmodule
